// File: rtl/spi_px_master_if.sv
// Parallel-side handshake bundle of the SPI pixel master: word in, word out, abort and busy.
interface spi_px_master_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  abort_i;
  logic                  rx_valid_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  busy_o;

  modport slave (
    input  tx_valid_i, tx_data_i, abort_i,
    output tx_ready_o, rx_valid_o, rx_data_o, busy_o
  );

  modport master (
    output tx_valid_i, tx_data_i, abort_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, busy_o
  );
endinterface

// File: rtl/spi_px_master.sv
// SPI mode-0 master: one full-duplex, MSB-first word per CS-low frame,
// with a valid/ready parallel side and a frame abort.
module spi_px_master #(
  parameter int DATA_WIDTH  = 24,
  parameter int CLK_DIV     = 4,
  parameter int CS_GAP      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            nreset_i,
  spi_px_master_if.slave  bus,
  output logic            spi_cs_o,
  output logic            spi_sck_o,
  output logic            spi_sdo_o,
  input  logic            spi_sdi_i
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   cs_q, cs_d;
  logic                   sck_q, sck_d;
  logic                   sdo_q, sdo_d;
  logic                   busy_q, busy_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;

  logic sdi_s;
  logic phase_end_s;
  logic abort_hit_s;

  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign phase_end_s = (div_cnt_q == DIV_LAST);
  assign abort_hit_s = bus.abort_i && ((state_q == ST_LEAD) || (state_q == ST_HI) ||
                                       (state_q == ST_LO)   || (state_q == ST_TRAIL));

  // Next-state, shift-register and pin logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    sdi_sync_d = (sdi_sync_q << 1) | SYNC_STAGES'(spi_sdi_i);

    if (abort_hit_s) begin
      // Abort beats every pending phase end, including the TRAIL terminal cycle.
      cs_d    = 1'b1;
      sck_d   = 1'b0;
      sdo_d   = 1'b0;
      state_d = ST_GAP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.tx_valid_i && tx_ready_q) begin
            tx_shift_d = bus.tx_data_i;
            cs_d       = 1'b0;
            sdo_d      = bus.tx_data_i[DATA_WIDTH-1];
            bit_cnt_d  = {BIT_W{1'b0}};
            state_d    = ST_LEAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (phase_end_s) begin
            sck_d   = 1'b1;
            state_d = ST_HI;
          end else begin
            state_d = ST_LEAD;
          end
        end
        ST_HI: begin
          if (phase_end_s) begin
            // Sampling at the end of the high phase hides synchronizer and slave latency.
            sck_d      = 1'b0;
            rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(sdi_s);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_TRAIL;
            end else begin
              bit_cnt_d  = bit_cnt_q + BIT_W'(1);
              tx_shift_d = tx_shift_q << 1;
              sdo_d      = tx_shift_d[DATA_WIDTH-1];
              state_d    = ST_LO;
            end
          end else begin
            state_d = ST_HI;
          end
        end
        ST_LO: begin
          if (phase_end_s) begin
            sck_d   = 1'b1;
            state_d = ST_HI;
          end else begin
            state_d = ST_LO;
          end
        end
        ST_TRAIL: begin
          if (phase_end_s) begin
            cs_d       = 1'b1;
            sdo_d      = 1'b0;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            state_d    = ST_GAP;
          end else begin
            state_d = ST_TRAIL;
          end
        end
        ST_GAP: begin
          if (div_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: begin
          cs_d    = 1'b1;
          sck_d   = 1'b0;
          sdo_d   = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end

    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      div_cnt_d = {CNT_W{1'b0}};
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end

    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= {CNT_W{1'b0}};
      bit_cnt_q  <= {BIT_W{1'b0}};
      tx_shift_q <= {DATA_WIDTH{1'b0}};
      rx_shift_q <= {DATA_WIDTH{1'b0}};
      rx_data_q  <= {DATA_WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      sdi_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      sdi_sync_q <= sdi_sync_d;
    end
  end

  assign bus.tx_ready_o = tx_ready_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.busy_o     = busy_q;
  assign spi_cs_o       = cs_q;
  assign spi_sck_o      = sck_q;
  assign spi_sdo_o      = sdo_q;

endmodule

// File: tb/tb_spi_px_master.sv
// Bench for spi_px_master: directed frames, a mode-0 slave model and
// scoreboard queues drained by monitors sampling on the falling clock edge.
module tb_spi_px_master;

  logic clk;
  logic nreset;
  logic cs, sck, sdo, sdi;
  logic cs8, sck8, sdo8, sdi8;

  int errors = 0;
  int checks = 0;

  spi_px_master_if #(.DATA_WIDTH(24)) bus ();
  spi_px_master_if #(.DATA_WIDTH(8))  bus8 ();

  spi_px_master #(.DATA_WIDTH(24), .CLK_DIV(4), .CS_GAP(2), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .nreset_i(nreset), .bus(bus),
    .spi_cs_o(cs), .spi_sck_o(sck), .spi_sdo_o(sdo), .spi_sdi_i(sdi)
  );

  spi_px_master #(.DATA_WIDTH(8), .CLK_DIV(4), .CS_GAP(2), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .nreset_i(nreset), .bus(bus8),
    .spi_cs_o(cs8), .spi_sck_o(sck8), .spi_sdo_o(sdo8), .spi_sdi_i(sdi8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [23:0] exp_rx[$];
  logic [23:0] exp_sdo[$];
  logic [23:0] slave_q[$];
  logic [7:0]  exp8[$];

  int rises = 0;
  int lo_cnt = 0;
  int hi_cnt = 0;
  int gap_len = 0;
  int rxv_cnt = 0;
  int sdo_viol = 0;
  int sdo_viol8 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and scoreboard for the 24-bit master.
  initial begin
    logic [23:0] sh;
    logic [23:0] cap;
    logic [23:0] e;
    logic prev_cs, prev_sck, prev_sdo;
    sh = 24'h0; cap = 24'h0;
    prev_cs = 1'b1; prev_sck = 1'b0; prev_sdo = 1'b0;
    sdi = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_valid_o === 1'b1) begin
        rxv_cnt++;
        if (exp_rx.size() == 0) begin
          chk("rx_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_rx.pop_front();
          chk("rx_data", {8'h0, bus.rx_data_o}, {8'h0, e});
        end
      end
      if (sck === 1'b1 && prev_sck === 1'b1 && sdo !== prev_sdo) sdo_viol++;
      if (prev_cs === 1'b1 && cs === 1'b0) begin
        gap_len = hi_cnt;
        lo_cnt = 0;
        rises = 0;
        sh = (slave_q.size() != 0) ? slave_q.pop_front() : 24'h0;
        sdi = sh[23];
      end else if (prev_cs === 1'b0 && cs === 1'b1) begin
        if (rises == 24) begin
          chk("cs_low_cycles", lo_cnt, 32'd196);
          if (exp_sdo.size() == 0) begin
            chk("sdo_unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_sdo.pop_front();
            chk("sdo_word", {8'h0, cap}, {8'h0, e});
          end
        end
        hi_cnt = 0;
      end
      if (cs === 1'b0) begin
        lo_cnt++;
        if (prev_sck === 1'b0 && sck === 1'b1) begin
          cap = {cap[22:0], sdo};
          rises++;
        end else if (prev_sck === 1'b1 && sck === 1'b0) begin
          sh = sh << 1;
          sdi = sh[23];
        end
      end else begin
        hi_cnt++;
      end
      prev_cs = cs; prev_sck = sck; prev_sdo = sdo;
    end
  end

  // Scoreboard for the 8-bit master whose SDI is tied by the stimulus.
  initial begin
    logic prev_sck8, prev_sdo8;
    logic [7:0] e8;
    prev_sck8 = 1'b0; prev_sdo8 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus8.rx_valid_o === 1'b1) begin
        if (exp8.size() == 0) begin
          chk("rx8_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e8 = exp8.pop_front();
          chk("rx8_data", {24'h0, bus8.rx_data_o}, {24'h0, e8});
        end
      end
      if (sck8 === 1'b1 && prev_sck8 === 1'b1 && sdo8 !== prev_sdo8) sdo_viol8++;
      prev_sck8 = sck8; prev_sdo8 = sdo8;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.tx_ready_o !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (bus.tx_ready_o !== 1'b1) chk("tx_ready_wait", {31'h0, bus.tx_ready_o}, 32'd1);
  endtask

  task automatic wait_ready8();
    int n;
    n = 0;
    while (bus8.tx_ready_o !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (bus8.tx_ready_o !== 1'b1) chk("tx8_ready_wait", {31'h0, bus8.tx_ready_o}, 32'd1);
  endtask

  task automatic wait_rise(input int k);
    int n;
    n = 0;
    while (!(rises == k && sck === 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    if (!(rises == k && sck === 1'b1)) chk("rise_wait", rises, k);
  endtask

  task automatic send(input logic [23:0] w, input logic [23:0] reply, input bit completes);
    wait_ready();
    slave_q.push_back(reply);
    if (completes) begin
      exp_rx.push_back(reply);
      exp_sdo.push_back(w);
    end
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = w;
    tick();
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = ~w;
  endtask

  task automatic send8(input logic [7:0] w, input logic [7:0] expv);
    wait_ready8();
    exp8.push_back(expv);
    bus8.tx_valid_i = 1'b1;
    bus8.tx_data_i  = w;
    tick();
    bus8.tx_valid_i = 1'b0;
    wait_ready8();
  endtask

  initial begin
    int base;
    nreset = 1'b0;
    sdi8 = 1'b0;
    bus.tx_valid_i = 1'b0;  bus.tx_data_i = 24'h0;  bus.abort_i = 1'b0;
    bus8.tx_valid_i = 1'b0; bus8.tx_data_i = 8'h0;  bus8.abort_i = 1'b0;
    repeat (3) tick();
    chk("rst_cs", {31'h0, cs}, 32'd1);
    chk("rst_sck", {31'h0, sck}, 32'd0);
    chk("rst_sdo", {31'h0, sdo}, 32'd0);
    chk("rst_rx_valid", {31'h0, bus.rx_valid_o}, 32'd0);
    chk("rst_rx_data", {8'h0, bus.rx_data_o}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'd0);
    chk("rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'd0);
    nreset = 1'b1;
    tick();
    chk("ready_after_rst", {31'h0, bus.tx_ready_o}, 32'd1);

    // Single frame with a known slave reply.
    send(24'hA5C3F0, 24'h00003C, 1'b1);
    chk("busy_in_frame", {31'h0, bus.busy_o}, 32'd1);
    wait_ready();

    // Back-to-back frames with tx_valid held high.
    base = rxv_cnt;
    slave_q.push_back(24'h123456); exp_rx.push_back(24'h123456); exp_sdo.push_back(24'h000001);
    slave_q.push_back(24'hABCDEF); exp_rx.push_back(24'hABCDEF); exp_sdo.push_back(24'hFFFFFF);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 24'h000001;
    tick();
    bus.tx_data_i  = 24'hFFFFFF;
    wait_ready();
    tick();
    bus.tx_valid_i = 1'b0;
    chk("gap_cycles", gap_len, 32'd3);
    wait_ready();
    chk("rx_pulses_b2b", rxv_cnt - base, 32'd2);

    // Abort in the high phase of bit 10.
    base = rxv_cnt;
    send(24'h0F1E2D, 24'h777777, 1'b0);
    wait_rise(11);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_cs", {31'h0, cs}, 32'd1);
    chk("abort_sck", {31'h0, sck}, 32'd0);
    chk("abort_sdo", {31'h0, sdo}, 32'd0);
    chk("abort_ready_gap", {31'h0, bus.tx_ready_o}, 32'd0);
    tick();
    chk("abort_ready_gap2", {31'h0, bus.tx_ready_o}, 32'd0);
    tick();
    chk("abort_ready_idle", {31'h0, bus.tx_ready_o}, 32'd1);
    chk("abort_busy_idle", {31'h0, bus.busy_o}, 32'd0);
    repeat (4) tick();
    chk("abort_rx_data_kept", {8'h0, bus.rx_data_o}, 32'hABCDEF);
    chk("abort_no_rx_pulse", rxv_cnt - base, 32'd0);

    // Reset for one cycle mid-frame at bit 5, then a clean transfer.
    send(24'h13579B, 24'h2468AC, 1'b0);
    wait_rise(6);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("mrst_cs", {31'h0, cs}, 32'd1);
    chk("mrst_sck", {31'h0, sck}, 32'd0);
    chk("mrst_sdo", {31'h0, sdo}, 32'd0);
    chk("mrst_rx_data", {8'h0, bus.rx_data_o}, 32'd0);
    chk("mrst_busy", {31'h0, bus.busy_o}, 32'd0);
    chk("mrst_tx_ready", {31'h0, bus.tx_ready_o}, 32'd0);
    tick();
    chk("mrst_ready_after", {31'h0, bus.tx_ready_o}, 32'd1);
    send(24'h5A5A5A, 24'h0F0F0F, 1'b1);
    wait_ready();

    // New requests while busy must not disturb the frame in flight.
    send(24'h3C3C3C, 24'h00FF00, 1'b1);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 24'hC3C3C3;
    repeat (40) tick();
    chk("busy_ignore_ready", {31'h0, bus.tx_ready_o}, 32'd0);
    chk("busy_ignore_busy", {31'h0, bus.busy_o}, 32'd1);
    bus.tx_valid_i = 1'b0;
    wait_ready();

    // 8-bit master with SDI tied high, then low.
    sdi8 = 1'b1;
    send8(8'h96, 8'hFF);
    sdi8 = 1'b0;
    send8(8'h69, 8'h00);
    repeat (4) tick();

    chk("sb_rx_drained", exp_rx.size(), 32'd0);
    chk("sb_sdo_drained", exp_sdo.size(), 32'd0);
    chk("sb_rx8_drained", exp8.size(), 32'd0);
    chk("sdo_stable_sck_high", sdo_viol, 32'd0);
    chk("sdo8_stable_sck_high", sdo_viol8, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_px_master.md
Name: spi_px_master

Overview:
- SPI mode-0 master: the host/bench-side counterpart of the chip's SPI pixel slave.
- Serializes one pixel word per transaction onto SDO and simultaneously deserializes the chip's reply from SDI (full duplex, MSB first).
- Used in FPGA test harnesses and the loopback testbench to feed frames into the gray/Sobel pipeline and collect results or signatures.
- One word per CS-low frame; valid/ready on the parallel side.

Parameters:
- DATA_WIDTH, 24: bits per transaction (pixel/signature width).
- CLK_DIV, 4: clk cycles per SCK half-period; legal values are 4 or more.
- CS_GAP, 2: minimum clk cycles CS stays high after a frame, before returning to IDLE.
- SYNC_STAGES, 2: flops on spi_sdi_i before sampling.

Ports:
- clk_i  in  1  system clock
- nreset_i  in  1  reset; synchronous, active-low
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  master idle, word accepted when valid&ready
- tx_data_i  in  DATA_WIDTH  word to send
- abort_i  in  1  terminate the current frame
- rx_valid_o  out  1  1-cycle pulse, rx_data_o updated
- rx_data_o  out  DATA_WIDTH  word received in the last completed frame
- busy_o  out  1  high from accept until IDLE re-entered
- spi_cs_o  out  1  chip select, active-low
- spi_sck_o  out  1  serial clock, idle low
- spi_sdo_o  out  1  master-out data
- spi_sdi_i  in  1  master-in data (asynchronous)

Behaviour:
- All logic is on posedge clk_i. Reset is synchronous, active-low, and applies at any point, including mid-frame.
- Reset values, from the first edge with nreset_i=0:
  - spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0
  - rx_valid_o=0, rx_data_o=0, busy_o=0, tx_ready_o=0
  - state=IDLE, synchronizer flops=0
- tx_ready_o=1 from the first edge after nreset_i=1.
- All outputs are registered. A divider counter runs 0..CLK_DIV-1; a phase ends when the counter reaches CLK_DIV-1. The counter clears on every state change.
- States: IDLE, LEAD, HI, LO, TRAIL, GAP.
- IDLE:
  - tx_ready_o=1.
  - On tx_valid_i&tx_ready_o, on the next edge: latch tx_data_i into the shift register, spi_cs_o<=0, spi_sdo_o<=tx_data_i[DATA_WIDTH-1], bit_cnt<=0, busy_o<=1, tx_ready_o<=0, state goes to LEAD.
- LEAD: after CLK_DIV cycles, spi_sck_o<=1 (rising edge; slave samples), go to HI.
- HI: after CLK_DIV cycles:
  - spi_sck_o<=0.
  - Capture the synchronized SDI into rx_shift LSB, shifting left. Sampling at the end of the high phase absorbs the SYNC_STAGES delay and slave latency.
  - If bit_cnt==DATA_WIDTH-1, go to TRAIL.
  - Otherwise bit_cnt++, spi_sdo_o<=next bit, go to LO.
- LO: after CLK_DIV cycles, spi_sck_o<=1, go to HI.
- TRAIL: after CLK_DIV cycles, spi_cs_o<=1, spi_sdo_o<=0, rx_data_o<=rx_shift, rx_valid_o<=1 for exactly one cycle, go to GAP.
- GAP: after CS_GAP cycles, go to IDLE, with busy_o<=0 and tx_ready_o<=1.
- Frame timing:
  - CS low for exactly CLK_DIV*(2*DATA_WIDTH+1) cycles.
  - DATA_WIDTH rising SCK edges per frame.
  - Minimum CS-high between back-to-back frames is CS_GAP+1 cycles (GAP plus the IDLE accept cycle).
- tx_valid_i outside IDLE is ignored, and tx_data_i changes after accept have no effect.
- abort_i:
  - In LEAD/HI/LO/TRAIL, on the next edge: spi_cs_o<=1, spi_sck_o<=0, spi_sdo_o<=0, go to GAP. No rx_valid_o, rx_data_o unchanged.
  - In IDLE or GAP it is ignored.
  - abort_i together with the TRAIL terminal cycle means abort wins: no rx_valid_o.
- SDO changes only while SCK is low, at least CLK_DIV cycles before each rising edge.

Test Plan:
- DATA_WIDTH=24, CLK_DIV=4; send 0xA5C3F0 with the slave model replying 0x00003C -> SDO bits are A5C3F0 MSB-first at 24 rising edges, CS low 196 cycles, one rx_valid_o pulse with rx_data_o=0x00003C.
- tx_valid_i held high with words 0x000001 then 0xFFFFFF, CS_GAP=2 -> two frames, CS high exactly 3 cycles between them, rx_valid_o pulses twice, received words correct.
- abort_i pulsed during the HI phase of bit 10 -> next edge CS=1, SCK=0, no rx_valid_o, rx_data_o retains its old value, tx_ready_o=1 after 3 cycles.
- nreset_i=0 for one cycle mid-frame at bit 5 -> next edge all outputs at reset values; a new transfer then completes correctly.
- New tx_valid_i/tx_data_i while busy_o=1 -> ignored, and the in-flight frame's SDO still carries the originally accepted word.
- SDI tied 1, DATA_WIDTH=8, CLK_DIV=4 -> rx_data_o=0xFF; SDI tied 0 -> 0x00; no SDO transition while SCK=1.
